jtbubl_gfx_romslot: RTL and testbench
=====================================

Name: jtbubl_gfx_romslot

Overview:
- Single-entry cached SDRAM read slot that sits directly upstream of the graphics engine.
- Turns the engine's tile/sprite ROM word requests (gfx_cs/gfx_addr) into SDRAM read handshakes.
- Returns gfx_data/gfx_ok to the engine.
- A repeated request to the last-fetched word is served with no SDRAM traffic.

Parameters:
- AW, 19: width of the graphics word address from the engine.
- SDW, 22: width of the SDRAM word address.
- OFFSET, 22'h08_0000: base of the graphics region in SDRAM, added to the slot address.

Ports:
- clk  in  1  system clock (48 MHz), the only clock.
- rst  in  1  synchronous, active-high reset.
- downloading  in  1  ROM download in progress. Flushes the slot and blocks requests.
- slot_cs  in  1  engine read request, level-held until slot_ok.
- slot_addr  in  AW  engine word address.
- slot_dout  out  16  returned ROM word.
- slot_ok  out  1  slot_dout is valid for the current slot_addr.
- sdram_addr  out  SDW  SDRAM word address, held for the whole request.
- sdram_req  out  1  SDRAM read request.
- sdram_ack  in  1  one-cycle pulse: controller accepted the request.
- data_rdy  in  1  one-cycle pulse: sdram_data is valid.
- sdram_data  in  16  SDRAM read data.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State returns to IDLE.
  - sdram_req=0, sdram_addr=0, slot_dout=0.
  - Cache valid=0, cached address=0.
  - Overrides any in-flight request, in any state.
- slot_ok is combinational: slot_cs & valid & (slot_addr==cached_addr) & ~downloading. It may rise in the same cycle as a hit.
- State machine: IDLE, WAIT_ACK, WAIT_DATA.
- IDLE:
  - A miss is slot_cs=1, ~downloading, and (~valid or address mismatch).
  - On a miss, at the next edge: req_addr<=slot_addr; sdram_addr<=OFFSET+slot_addr (zero-extended, modulo 2^SDW); sdram_req<=1; go to WAIT_ACK.
  - Valid is not cleared; the stale entry still answers its own address.
- WAIT_ACK:
  - sdram_req is held high and sdram_addr is held constant.
  - On sdram_ack: sdram_req<=0, go to WAIT_DATA.
  - data_rdy in this state is ignored.
- WAIT_DATA:
  - On data_rdy: slot_dout<=sdram_data, cached_addr<=req_addr, valid<=1, go to IDLE.
- Latency:
  - Hit: 0 cycles.
  - Miss: 1 cycle to raise req, plus controller ack latency, plus data latency, plus 1 cycle (registered data). slot_ok is high in the cycle after data_rdy.
- A new miss cannot start in the same cycle as data_rdy. IDLE re-evaluates one cycle later.
- slot_addr changes mid-request: the in-flight request is completed and cached (no abort). slot_ok stays low because of the mismatch, then a new miss starts from IDLE.
- slot_cs drops mid-request: the request still completes and is cached, with no new request.
- downloading=1 in any state:
  - Next edge: sdram_req<=0, valid<=0, state IDLE.
  - No requests while it is high.
  - Any late data_rdy is discarded.
- sdram_ack and data_rdy in the same cycle while in WAIT_ACK: the ack is taken, the data is ignored, and the block waits for a later data_rdy.
- Exactly one request is outstanding at any time.

Test Plan:
- Reset then cold miss: slot_cs=1, slot_addr=19'h00123 → next cycle sdram_req=1, sdram_addr=22'h080123. Ack 3 cycles later, data_rdy with 16'hBEEF 4 cycles after that → slot_dout=16'hBEEF and slot_ok=1 in the cycle after data_rdy.
- Hit: keep slot_addr=19'h00123 after the fill, toggle slot_cs 0→1 → slot_ok=1 in the same cycle, sdram_req stays 0 throughout.
- Address change mid-request: during WAIT_DATA switch to 19'h00124 → slot_ok stays 0 when data_rdy arrives for 0x123. The next cycle raises sdram_req with sdram_addr=22'h080124.
- Address wrap: OFFSET=22'h3F_FFF0, slot_addr=19'h00020 → sdram_addr=22'h000010.
- Flush: assert downloading during WAIT_ACK → sdram_req=0 next cycle, slot_ok=0, no request while high. A stray data_rdy with 16'h1234 leaves slot_dout unchanged.
- Reset mid-request: rst=1 in WAIT_DATA → all outputs zero at the next edge. A later data_rdy is not captured, and the same address re-requests after rst falls.

Source files
------------

// File: rtl/jtbubl_gfx_romslot.sv
// Single-entry cached ROM read slot between the graphics engine and the SDRAM controller.
// A repeat of the last fetched word answers in the same cycle with no SDRAM traffic.
module jtbubl_gfx_romslot #(
    parameter int             AW     = 19,
    parameter int             SDW    = 22,
    parameter logic [SDW-1:0] OFFSET = 22'h08_0000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           downloading,
    input  logic           slot_cs,
    input  logic [AW-1:0]  slot_addr,
    output logic [15:0]    slot_dout,
    output logic           slot_ok,
    output logic [SDW-1:0] sdram_addr,
    output logic           sdram_req,
    input  logic           sdram_ack,
    input  logic           data_rdy,
    input  logic [15:0]    sdram_data
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        WAIT_DATA
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  req_addr_q, req_addr_d;
    logic [AW-1:0]  cached_addr_q, cached_addr_d;
    logic           valid_q, valid_d;
    logic [15:0]    dout_q, dout_d;
    logic [SDW-1:0] sdram_addr_q, sdram_addr_d;
    logic           sdram_req_q, sdram_req_d;

    logic hit;
    logic miss;

    // A stale entry keeps answering its own address while a different word is in flight.
    assign hit     = valid_q & (slot_addr == cached_addr_q);
    assign miss    = slot_cs & ~downloading & ~hit;
    assign slot_ok = slot_cs & hit & ~downloading;

    assign slot_dout  = dout_q;
    assign sdram_addr = sdram_addr_q;
    assign sdram_req  = sdram_req_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        cached_addr_d = cached_addr_q;
        valid_d       = valid_q;
        dout_d        = dout_q;
        sdram_addr_d  = sdram_addr_q;
        sdram_req_d   = sdram_req_q;

        if (downloading) begin
            // Flush: drop any in-flight request; late data_rdy then lands in IDLE and is ignored.
            state_d     = IDLE;
            sdram_req_d = 1'b0;
            valid_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        req_addr_d   = slot_addr;
                        sdram_addr_d = OFFSET + SDW'(slot_addr);
                        sdram_req_d  = 1'b1;
                        state_d      = WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        sdram_req_d = 1'b0;
                        state_d     = WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (data_rdy) begin
                        dout_d        = sdram_data;
                        cached_addr_d = req_addr_q;
                        valid_d       = 1'b1;
                        state_d       = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q       <= IDLE;
            req_addr_q    <= '0;
            cached_addr_q <= '0;
            valid_q       <= 1'b0;
            dout_q        <= '0;
            sdram_addr_q  <= '0;
            sdram_req_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            cached_addr_q <= cached_addr_d;
            valid_q       <= valid_d;
            dout_q        <= dout_d;
            sdram_addr_q  <= sdram_addr_d;
            sdram_req_q   <= sdram_req_d;
        end
    end

endmodule

// File: tb/tb_jtbubl_gfx_romslot.sv
// Bench for jtbubl_gfx_romslot: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a transaction-level model of the slot.
module tb_jtbubl_gfx_romslot;

    localparam int             AW   = 19;
    localparam int             SDW  = 22;
    localparam logic [SDW-1:0] OFF1 = 22'h08_0000;
    localparam logic [SDW-1:0] OFF2 = 22'h3F_FFF0;

    logic           clk = 1'b0;
    logic           rst;
    logic           downloading;
    logic           slot_cs;
    logic [AW-1:0]  slot_addr;
    logic           sdram_ack;
    logic           data_rdy;
    logic [15:0]    sdram_data;

    logic [15:0]    slot_dout,  slot_dout2;
    logic           slot_ok,    slot_ok2;
    logic [SDW-1:0] sdram_addr, sdram_addr2;
    logic           sdram_req,  sdram_req2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtbubl_gfx_romslot #(.AW(AW), .SDW(SDW), .OFFSET(OFF1)) dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(slot_dout), .slot_ok(slot_ok),
        .sdram_addr(sdram_addr), .sdram_req(sdram_req),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_data(sdram_data)
    );

    jtbubl_gfx_romslot #(.AW(AW), .SDW(SDW), .OFFSET(OFF2)) dut2 (
        .clk(clk), .rst(rst), .downloading(downloading),
        .slot_cs(slot_cs), .slot_addr(slot_addr),
        .slot_dout(slot_dout2), .slot_ok(slot_ok2),
        .sdram_addr(sdram_addr2), .sdram_req(sdram_req2),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .sdram_data(sdram_data)
    );

    // Model: the cached word plus at most one outstanding request, described as a transaction.
    bit          m_valid  = 0;
    int unsigned m_caddr  = 0;
    int unsigned m_dout   = 0;
    bit          m_busy   = 0;
    bit          m_acked  = 0;
    int unsigned m_raddr  = 0;
    int unsigned m_sd1    = 0;
    int unsigned m_sd2    = 0;

    function automatic int unsigned sd_of(input int unsigned off, input int unsigned a);
        return int'((longint'(off) + longint'(a)) % 64'h40_0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_valid = 0; m_caddr = 0; m_dout = 0;
            m_busy  = 0; m_acked = 0; m_sd1  = 0; m_sd2 = 0;
        end else if (downloading) begin
            m_busy  = 0;
            m_valid = 0;
        end else if (!m_busy) begin
            if (slot_cs && !(m_valid && slot_addr == m_caddr)) begin
                m_busy  = 1;
                m_acked = 0;
                m_raddr = slot_addr;
                m_sd1   = sd_of(OFF1, slot_addr);
                m_sd2   = sd_of(OFF2, slot_addr);
            end
        end else if (!m_acked) begin
            if (sdram_ack) m_acked = 1;
        end else if (data_rdy) begin
            m_dout  = sdram_data;
            m_caddr = m_raddr;
            m_valid = 1;
            m_busy  = 0;
        end
    endtask

    task automatic compare_all();
        logic exp_ok;
        logic exp_req;
        exp_ok  = slot_cs && m_valid && (slot_addr == m_caddr) && !downloading;
        exp_req = m_busy && !m_acked;
        check("ok",    slot_ok,     exp_ok);
        check("req",   sdram_req,   exp_req);
        check("addr",  sdram_addr,  m_sd1);
        check("dout",  slot_dout,   m_dout);
        check("ok2",   slot_ok2,    exp_ok);
        check("req2",  sdram_req2,  exp_req);
        check("addr2", sdram_addr2, m_sd2);
        check("dout2", slot_dout2,  m_dout);
    endtask

    // Inputs are changed by the caller just after a rising edge; the model advances on the edge.
    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic pulse_ack();
        sdram_ack = 1'b1; tick(); sdram_ack = 1'b0;
    endtask

    task automatic pulse_data(input logic [15:0] d);
        data_rdy = 1'b1; sdram_data = d; tick(); data_rdy = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not end, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; downloading = 1'b0; slot_cs = 1'b0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; sdram_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",  sdram_req,  0);
        check("rst_addr", sdram_addr, 0);
        check("rst_dout", slot_dout,  0);
        check("rst_ok",   slot_ok,    0);

        // Cold miss, ack after 3 cycles, data 4 cycles after that.
        rst = 1'b0; slot_cs = 1'b1; slot_addr = 19'h00123;
        #1 check("cold_ok0", slot_ok, 0);
        tick();
        check("cold_req",  sdram_req,  1);
        check("cold_addr", sdram_addr, 22'h080123);
        tick(); tick();
        pulse_ack();
        check("cold_req_dropped", sdram_req, 0);
        tick(); tick(); tick();
        pulse_data(16'hBEEF);
        check("cold_dout", slot_dout, 16'hBEEF);
        check("cold_ok",   slot_ok,   1);

        // Hit: slot_ok in the same cycle as slot_cs, no SDRAM request.
        slot_cs = 1'b0;
        #1 check("hit_ok_cs0", slot_ok, 0);
        tick();
        slot_cs = 1'b1;
        #1 check("hit_ok", slot_ok, 1);
        tick();
        check("hit_noreq", sdram_req, 0);

        // Address change while waiting for data.
        slot_addr = 19'h00100; tick(); pulse_ack(); pulse_data(16'h1111);
        slot_addr = 19'h00123; tick(); pulse_ack();
        slot_addr = 19'h00124; tick();
        pulse_data(16'h5555);
        check("chg_ok",   slot_ok,   0);
        check("chg_req",  sdram_req, 0);
        check("chg_dout", slot_dout, 16'h5555);
        tick();
        check("chg_req2",  sdram_req,  1);
        check("chg_addr2", sdram_addr, 22'h080124);
        pulse_ack(); pulse_data(16'h2222);

        // Address wrap on the high-offset instance.
        slot_addr = 19'h00020; tick();
        check("wrap_addr",  sdram_addr2, 22'h000010);
        check("plain_addr", sdram_addr,  22'h080020);
        pulse_ack(); pulse_data(16'hA5A5);
        check("wrap_dout", slot_dout, 16'hA5A5);

        // Flush during WAIT_ACK, stray data while downloading.
        slot_addr = 19'h00030; tick();
        downloading = 1'b1;
        #1 check("flush_ok", slot_ok, 0);
        tick();
        check("flush_req", sdram_req, 0);
        tick(); tick();
        pulse_data(16'h1234);
        check("flush_dout", slot_dout, 16'hA5A5);
        check("flush_req2", sdram_req, 0);
        downloading = 1'b0;
        tick(); pulse_ack(); pulse_data(16'h3333);

        // Reset in WAIT_DATA, late data ignored, same address re-requested.
        slot_addr = 19'h00040; tick(); pulse_ack();
        rst = 1'b1; tick();
        check("mrst_req",  sdram_req,  0);
        check("mrst_addr", sdram_addr, 0);
        check("mrst_dout", slot_dout,  0);
        check("mrst_ok",   slot_ok,    0);
        rst = 1'b0;
        pulse_data(16'h7777);
        check("mrst_rereq", sdram_req,  1);
        check("mrst_raddr", sdram_addr, 22'h080040);
        check("mrst_dout2", slot_dout,  0);
        pulse_ack(); pulse_data(16'h4444);

        // Random traffic: stray acks/data, flushes and resets all appear.
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            downloading = ($urandom_range(0, 39) == 0);
            slot_cs     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 3))
                    0: slot_addr = 19'h00123;
                    1: slot_addr = 19'h00124;
                    2: slot_addr = 19'h7FFFF;
                    default: slot_addr = AW'($urandom);
                endcase
            end
            sdram_ack  = ($urandom_range(0, 2) == 0);
            data_rdy   = ($urandom_range(0, 2) == 0);
            sdram_data = 16'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
